// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register map, SR/CAUSE field positions, exception
// source ordering, ExcCode table and FSM state type.
package cp0_pkg;

  localparam logic [4:0] REG_BADVA   = 5'd8;
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam int unsigned SR_IE     = 0;
  localparam int unsigned SR_EXL    = 1;
  localparam int unsigned SR_UM     = 4;
  localparam int unsigned SR_IM_LO  = 8;
  localparam logic [31:0] SR_WMASK  = 32'h0000_FF13;
  localparam logic [31:0] SR_RESET  = 32'h0000_0010;

  localparam int unsigned CAUSE_CODE_LO = 2;
  localparam int unsigned CAUSE_IP_LO   = 8;
  localparam int unsigned CAUSE_IRQ_LO  = 10;
  localparam int unsigned CAUSE_TIP     = 15;

  // Bit positions in exc_valid; lower bit = higher priority.
  localparam int unsigned EXC_ADDRL   = 0;
  localparam int unsigned EXC_ADDRS   = 1;
  localparam int unsigned EXC_RI      = 2;
  localparam int unsigned EXC_OVF     = 3;
  localparam int unsigned EXC_TR      = 4;
  localparam int unsigned EXC_SYSCALL = 5;

  localparam logic [4:0] CODE_INT     = 5'd0;
  localparam logic [4:0] CODE_ADDRL   = 5'd4;
  localparam logic [4:0] CODE_ADDRS   = 5'd5;
  localparam logic [4:0] CODE_SYSCALL = 5'd8;
  localparam logic [4:0] CODE_RI      = 5'd10;
  localparam logic [4:0] CODE_OVF     = 5'd12;
  localparam logic [4:0] CODE_TR      = 5'd13;

  typedef enum logic [1:0] {StRun, StEnter, StReturn} cp0_state_e;

  function automatic logic [4:0] exc_code(input logic [31:0] idx);
    case (idx)
      EXC_ADDRL:   return CODE_ADDRL;
      EXC_ADDRS:   return CODE_ADDRS;
      EXC_RI:      return CODE_RI;
      EXC_OVF:     return CODE_OVF;
      EXC_TR:      return CODE_TR;
      EXC_SYSCALL: return CODE_SYSCALL;
      default:     return CODE_INT;
    endcase
  endfunction

endpackage

// File: rtl/cp0_prio_enc.sv
// Priority encoder: reports whether any request is set and the index of the
// lowest set bit.
module cp0_prio_enc #(
  parameter int unsigned Width = 6,
  parameter int unsigned IdxW  = 3
) (
  input  logic [Width-1:0] req_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/cp0_exception_unit.sv
// Coprocessor 0: exception/interrupt prioritisation, status registers, timer
// and one-cycle registered pipeline redirect on exception entry and eret.
module cp0_exception_unit
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_EXC    = 6,
  parameter int unsigned NUM_IRQ    = 5,
  parameter logic [31:0] KERNEL_VEC = 32'h8000_0180,
  parameter bit          TIMER_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mtc0_en_i,
  input  logic [4:0]         wreg_i,
  input  logic [31:0]        wdata_i,
  input  logic [4:0]         rreg_i,
  output logic [31:0]        rdata_o,
  input  logic [NUM_EXC-1:0] exc_valid_i,
  input  logic [31:0]        exc_pc_i,
  input  logic [31:0]        exc_badva_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               eret_i,
  output logic               flush_o,
  output logic               pc_select_o,
  output logic [31:0]        pc_target_o,
  output logic [31:0]        epc_o,
  output logic               cpu_mode_o
);

  localparam int unsigned IdxW = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;

  cp0_state_e  state_q, state_d;
  logic        flush_q, flush_d;
  logic        pc_sel_q, pc_sel_d;
  logic [31:0] pc_target_q, pc_target_d;
  logic [31:0] badva_q, badva_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] sr_q, sr_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  logic            exc_any;
  logic [IdxW-1:0] exc_idx;
  logic [31:0]     win_idx;
  logic            int_req;

  cp0_prio_enc #(
    .Width (NUM_EXC),
    .IdxW  (IdxW)
  ) u_prio_enc (
    .req_i   (exc_valid_i),
    .valid_o (exc_any),
    .idx_o   (exc_idx)
  );

  assign win_idx = {{(32 - IdxW){1'b0}}, exc_idx};
  assign int_req = sr_q[SR_IE] & ~sr_q[SR_EXL] &
                   (|(cause_q[CAUSE_IP_LO +: 8] & sr_q[SR_IM_LO +: 8]));

  always_comb begin
    state_d     = state_q;
    flush_d     = 1'b0;
    pc_sel_d    = 1'b0;
    pc_target_d = pc_target_q;
    badva_d     = badva_q;
    count_d     = count_q;
    compare_d   = compare_q;
    sr_d        = sr_q;
    cause_d     = cause_q;
    epc_d       = epc_q;

    if (TIMER_EN) begin
      count_d = count_q + 32'd1;
      if (count_q == compare_q) cause_d[CAUSE_TIP] = 1'b1;
    end
    cause_d[CAUSE_IRQ_LO +: NUM_IRQ] = irq_i;

    // Software writes first so that exception field updates below override them.
    if (mtc0_en_i) begin
      case (wreg_i)
        REG_COUNT: if (TIMER_EN) count_d = wdata_i;
        REG_COMPARE: begin
          if (TIMER_EN) begin
            compare_d          = wdata_i;
            cause_d[CAUSE_TIP] = 1'b0;
          end
        end
        REG_SR:    sr_d = wdata_i & SR_WMASK;
        REG_CAUSE: cause_d[CAUSE_IP_LO +: 2] = wdata_i[CAUSE_IP_LO +: 2];
        REG_EPC:   epc_d = wdata_i;
        default: ;
      endcase
    end

    unique case (state_q)
      StRun: begin
        if (exc_any || int_req) begin
          state_d     = StEnter;
          flush_d     = 1'b1;
          pc_sel_d    = 1'b1;
          pc_target_d = KERNEL_VEC;
          cause_d[CAUSE_CODE_LO +: 5] = exc_any ? exc_code(win_idx) : CODE_INT;
          if (!sr_q[SR_EXL]) epc_d = exc_pc_i;
          sr_d[SR_EXL] = 1'b1;
          if (exc_any && (win_idx == EXC_ADDRL || win_idx == EXC_ADDRS)) begin
            badva_d = exc_badva_i;
          end
        end else if (eret_i) begin
          state_d      = StReturn;
          flush_d      = 1'b1;
          pc_sel_d     = 1'b1;
          pc_target_d  = epc_q;
          sr_d[SR_EXL] = 1'b0;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      flush_q     <= 1'b0;
      pc_sel_q    <= 1'b0;
      pc_target_q <= '0;
      badva_q     <= '0;
      count_q     <= '0;
      compare_q   <= 32'hFFFF_FFFF;
      sr_q        <= SR_RESET;
      cause_q     <= '0;
      epc_q       <= '0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      pc_sel_q    <= pc_sel_d;
      pc_target_q <= pc_target_d;
      badva_q     <= badva_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      sr_q        <= sr_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (rreg_i)
      REG_BADVA:   rdata_o = badva_q;
      REG_COUNT:   rdata_o = TIMER_EN ? count_q : '0;
      REG_COMPARE: rdata_o = TIMER_EN ? compare_q : '0;
      REG_SR:      rdata_o = sr_q;
      REG_CAUSE:   rdata_o = cause_q;
      REG_EPC:     rdata_o = epc_q;
      default: ;
    endcase
  end

  assign flush_o     = flush_q;
  assign pc_select_o = pc_sel_q;
  assign pc_target_o = pc_target_q;
  assign epc_o       = epc_q;
  assign cpu_mode_o  = sr_q[SR_EXL] | ~sr_q[SR_UM];

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Scoreboard bench for cp0_exception_unit: directed stimulus pushes expected
// redirect targets; a negedge monitor pops and checks every redirect pulse.
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mtc0_en;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [4:0]  rreg;
  logic [31:0] rdata;
  logic [5:0]  exc_valid;
  logic [31:0] exc_pc;
  logic [31:0] exc_badva;
  logic [4:0]  irq;
  logic        eret;
  logic        flush;
  logic        pc_select;
  logic [31:0] pc_target;
  logic [31:0] epc;
  logic        cpu_mode;

  int total = 0;
  int bad = 0;
  int n_redir = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  cp0_exception_unit dut (
    .clk         (clk),
    .reset       (reset),
    .mtc0_en_i   (mtc0_en),
    .wreg_i      (wreg),
    .wdata_i     (wdata),
    .rreg_i      (rreg),
    .rdata_o     (rdata),
    .exc_valid_i (exc_valid),
    .exc_pc_i    (exc_pc),
    .exc_badva_i (exc_badva),
    .irq_i       (irq),
    .eret_i      (eret),
    .flush_o     (flush),
    .pc_select_o (pc_select),
    .pc_target_o (pc_target),
    .epc_o       (epc),
    .cpu_mode_o  (cpu_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] idx, output logic [31:0] v);
    rreg = idx;
    #1;
    v = rdata;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    mtc0_en = 1'b1;
    wreg    = idx;
    wdata   = d;
    step();
    mtc0_en = 1'b0;
  endtask

  task automatic wait_redir(input int max, output int n);
    n = 0;
    for (int k = 1; k <= max; k++) begin
      step();
      if (pc_select) begin
        n = k;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset && pc_select) begin
      n_redir++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_redirect: got target %h want no redirect", pc_target);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("redirect_target", pc_target, mon_exp);
        chk("redirect_flush", {31'b0, flush}, 32'h1);
      end
    end
  end

  logic [31:0] v;
  logic [31:0] c;
  int n;
  int m;

  initial begin
    reset = 1'b1; mtc0_en = 1'b0; wreg = '0; wdata = '0; rreg = '0;
    exc_valid = '0; exc_pc = '0; exc_badva = '0; irq = '0; eret = 1'b0;
    step(); step();
    reset = 1'b0;

    rd(5'd12, v); chk("reset_sr", v, 32'h10);
    rd(5'd11, v); chk("reset_compare", v, 32'hFFFF_FFFF);
    chk("reset_flush", {31'b0, flush}, 32'h0);
    chk("reset_pc_select", {31'b0, pc_select}, 32'h0);
    chk("reset_epc", epc, 32'h0);
    chk("reset_cpu_mode", {31'b0, cpu_mode}, 32'h0);

    // Reserved instruction.
    exc_pc = 32'h0040_0020; exc_valid = 6'b000100;
    exp_q.push_back(32'h8000_0180);
    step(); exc_valid = '0;
    chk("ri_epc", epc, 32'h0040_0020);
    rd(5'd13, v); chk("ri_code", (v >> 2) & 32'h1f, 32'd10);
    rd(5'd12, v); chk("ri_sr", v, 32'h12);
    chk("ri_cpu_mode", {31'b0, cpu_mode}, 32'h1);
    step();
    eret = 1'b1; exp_q.push_back(32'h0040_0020);
    step(); eret = 1'b0;
    rd(5'd12, v); chk("eret1_sr", v, 32'h10);
    step();

    // ADDRL and OVF together: ADDRL wins.
    exc_pc = 32'h0040_0100; exc_badva = 32'h1003; exc_valid = 6'b001001;
    exp_q.push_back(32'h8000_0180);
    step(); exc_valid = '0;
    rd(5'd13, v); chk("addrl_code", (v >> 2) & 32'h1f, 32'd4);
    rd(5'd8, v);  chk("addrl_badva", v, 32'h1003);
    chk("addrl_epc", epc, 32'h0040_0100);
    step();

    // Nested syscall with EXL set: EPC kept.
    exc_pc = 32'h0040_0200; exc_badva = 32'h5555; exc_valid = 6'b100000;
    exp_q.push_back(32'h8000_0180);
    step(); exc_valid = '0;
    chk("nested_epc", epc, 32'h0040_0100);
    rd(5'd13, v); chk("nested_code", (v >> 2) & 32'h1f, 32'd8);
    rd(5'd8, v);  chk("nested_badva", v, 32'h1003);
    step();
    wr(5'd8, 32'hDEAD_BEEF);
    rd(5'd8, v);  chk("badva_readonly", v, 32'h1003);
    eret = 1'b1; exp_q.push_back(32'h0040_0100);
    step(); eret = 1'b0;
    rd(5'd12, v); chk("eret2_sr", v, 32'h10);
    step();

    // Exception and eret in the same cycle: only the exception redirects.
    exc_pc = 32'h0040_0300; exc_valid = 6'b010000; eret = 1'b1;
    exp_q.push_back(32'h8000_0180);
    step(); exc_valid = '0; eret = 1'b0;
    rd(5'd13, v); chk("tr_code", (v >> 2) & 32'h1f, 32'd13);
    chk("tr_epc", epc, 32'h0040_0300);
    step();
    eret = 1'b1; exp_q.push_back(32'h0040_0300);
    step(); eret = 1'b0;
    step();

    wr(5'd9, 32'd100);
    rd(5'd9, v); chk("count_write", v, 32'd100);

    // External interrupt with IE=1, IM2 set.
    wr(5'd12, 32'h0401);
    exc_pc = 32'h0040_0400; irq = 5'b00001;
    exp_q.push_back(32'h8000_0180);
    wait_redir(8, n);
    chk("irq_latency", n, 32'd2);
    rd(5'd13, v); chk("irq_code", (v >> 2) & 32'h1f, 32'd0);
    step(); irq = '0; step();
    eret = 1'b1; exp_q.push_back(32'h0040_0400);
    step(); eret = 1'b0;
    step();

    // Same interrupt with IE=0: no redirect.
    wr(5'd12, 32'h0400);
    irq = 5'b00001; m = n_redir;
    repeat (6) step();
    rd(5'd13, v); chk("irq_ip_sampled", v & 32'h400, 32'h400);
    chk("irq_masked_no_redirect", n_redir, m);
    irq = '0; step();

    // Timer interrupt.
    wr(5'd12, 32'h8001);
    exc_pc = 32'h0040_0500;
    rd(5'd9, c);
    mtc0_en = 1'b1; wreg = 5'd11; wdata = c + 32'd5;
    exp_q.push_back(32'h8000_0180);
    step(); mtc0_en = 1'b0;
    wait_redir(12, n);
    chk("timer_latency", n, 32'd6);
    rd(5'd13, v); chk("timer_tip_set", v & 32'h8000, 32'h8000);
    chk("timer_code", (v >> 2) & 32'h1f, 32'd0);
    step();
    wr(5'd11, 32'hFFFF_FFFF);
    rd(5'd13, v); chk("timer_tip_clear", v & 32'h8000, 32'h0);
    eret = 1'b1; exp_q.push_back(32'h0040_0500);
    step(); eret = 1'b0;
    step();

    // Reset during ENTER.
    exc_badva = 32'h2000; exc_valid = 6'b000001;
    exp_q.push_back(32'h8000_0180);
    step(); exc_valid = '0;
    @(negedge clk); #1;
    reset = 1'b1;
    step();
    chk("rst_pc_select", {31'b0, pc_select}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_pc_target", pc_target, 32'h0);
    chk("rst_epc", epc, 32'h0);
    rd(5'd12, v); chk("rst_sr", v, 32'h10);
    rd(5'd8, v);  chk("rst_badva", v, 32'h0);
    reset = 1'b0;
    step(); step();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
